// File: rtl/cvp14_mem_responder.sv
// Word-addressed 16-bit memory for the CVP14 core bus with a side-channel loader.
// Optional power-on clear sweep is enabled with `define CVP14_MEM_CLEAR_EN.
module cvp14_mem_responder #(
  parameter int          ADDR_W   = 10,
  parameter logic [15:0] INIT_VAL = 16'h0000
) (
  input  logic        Clk1,
  input  logic        Reset,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic [15:0] dataOut,
  output logic [15:0] DataIn,
  input  logic        ld_valid,
  input  logic [15:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ready,
  output logic        busy,
  output logic        err,
  output logic [15:0] wr_count
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [15:0]       mem_q [DEPTH];
  logic [15:0]       data_q, data_d;
  logic              err_q, err_d;
  logic [15:0]       cnt_q, cnt_d;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [15:0]       mem_wdata;
  logic              idle;
  logic              addr_ok, ld_addr_ok;

  assign addr_ok    = (Addr >> ADDR_W) == '0;
  assign ld_addr_ok = (ld_addr >> ADDR_W) == '0;

`ifdef CVP14_MEM_CLEAR_EN
  typedef enum logic {S_CLEAR, S_IDLE} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_q, sweep_d;

  assign idle = (state_q == S_IDLE);
  assign busy = (state_q == S_CLEAR);
`else
  assign idle = 1'b1;
  assign busy = 1'b0;
`endif

  // Core bus has priority: the loader only gets a slot on cycles the core leaves idle.
  assign ld_ready = idle & ~RD & ~WR & ~Reset;

  always_comb begin
    data_d    = data_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;
`ifdef CVP14_MEM_CLEAR_EN
    state_d   = state_q;
    sweep_d   = sweep_q;
`endif
    if (!Reset) begin
`ifdef CVP14_MEM_CLEAR_EN
      if (state_q == S_CLEAR) begin
        mem_we    = 1'b1;
        mem_waddr = sweep_q;
        mem_wdata = INIT_VAL;
        sweep_d   = sweep_q + ADDR_W'(1);
        if (sweep_q == '1) state_d = S_IDLE;
      end else
`endif
      if (RD && WR) begin
        err_d = 1'b1;
      end else if (RD) begin
        if (addr_ok) begin
          data_d = mem_q[Addr[ADDR_W-1:0]];
        end else begin
          data_d = '0;
          err_d  = 1'b1;
        end
      end else if (WR) begin
        if (addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = Addr[ADDR_W-1:0];
          mem_wdata = dataOut;
          if (cnt_q != '1) cnt_d = cnt_q + 16'd1;
        end else begin
          err_d = 1'b1;
        end
      end else if (ld_valid && ld_ready) begin
        if (ld_addr_ok) begin
          mem_we    = 1'b1;
          mem_waddr = ld_addr[ADDR_W-1:0];
          mem_wdata = ld_data;
        end else begin
          err_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk1) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      data_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef CVP14_MEM_CLEAR_EN
      state_q <= S_CLEAR;
      sweep_q <= '0;
`endif
    end else begin
      data_q  <= data_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
`ifdef CVP14_MEM_CLEAR_EN
      state_q <= state_d;
      sweep_q <= sweep_d;
`endif
    end
  end

  assign DataIn   = data_q;
  assign err      = err_q;
  assign wr_count = cnt_q;

endmodule

// File: tb/tb_cvp14_mem_responder.sv
// Directed vector-table bench for cvp14_mem_responder; covers the clear sweep
// when built with CVP14_MEM_CLEAR_EN.
module tb_cvp14_mem_responder;

`ifdef CVP14_MEM_CLEAR_EN
  localparam int AW = 4;
`else
  localparam int AW = 10;
`endif
  localparam int          DEPTH = 1 << AW;
  localparam logic [15:0] INIT  = 16'hA5A5;

  logic        Clk1 = 1'b0;
  logic        Reset, RD, WR, ld_valid;
  logic [15:0] Addr, dataOut, ld_addr, ld_data;
  logic [15:0] DataIn, wr_count;
  logic        ld_ready, busy, err;
  logic        ldr_s;
  int          tests = 0;
  int          fails = 0;

  cvp14_mem_responder #(.ADDR_W(AW), .INIT_VAL(INIT)) dut (
    .Clk1(Clk1), .Reset(Reset), .Addr(Addr), .RD(RD), .WR(WR), .dataOut(dataOut),
    .DataIn(DataIn), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ready(ld_ready), .busy(busy), .err(err), .wr_count(wr_count)
  );

  always #5 Clk1 = ~Clk1;

  typedef struct {
    logic rd; logic wr; logic [15:0] addr; logic [15:0] dout;
    logic ldv; logic [15:0] lda; logic [15:0] ldd;
    logic exp_ldr; logic [15:0] exp_data; logic exp_err; logic [15:0] exp_cnt;
  } vec_t;
  vec_t vq[$];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic vec(input logic rd, wr, input logic [15:0] a, d, input logic lv,
                     input logic [15:0] la, ld, input logic xl, input logic [15:0] xd,
                     input logic xe, input logic [15:0] xc);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.dout = d; v.ldv = lv; v.lda = la; v.ldd = ld;
    v.exp_ldr = xl; v.exp_data = xd; v.exp_err = xe; v.exp_cnt = xc;
    vq.push_back(v);
  endtask

  // Drive inputs at negedge, capture ld_ready just before the edge, return 1ns after it.
  task automatic cyc(input logic rd, wr, input logic [15:0] a, d, input logic lv,
                     input logic [15:0] la, ld);
    @(negedge Clk1);
    RD = rd; WR = wr; Addr = a; dataOut = d; ld_valid = lv; ld_addr = la; ld_data = ld;
    #1 ldr_s = ld_ready;
    @(posedge Clk1);
    #1;
  endtask

  task automatic wait_clear(input string name);
`ifdef CVP14_MEM_CLEAR_EN
    int n = 0;
    chk({name, "_busy_start"}, {15'd0, busy}, 16'd1);
    chk({name, "_ldr_clear"}, {15'd0, ld_ready}, 16'd0);
    while (busy && n < DEPTH + 8) begin
      @(posedge Clk1);
      #1 n++;
    end
    chk({name, "_busy_cycles"}, 16'(n), 16'(DEPTH));
`else
    chk({name, "_busy"}, {15'd0, busy}, 16'd0);
`endif
  endtask

  task automatic do_reset(input logic wr_during);
    @(negedge Clk1);
    Reset = 1'b1; RD = 1'b0; WR = wr_during; Addr = 16'd7; dataOut = 16'h9999;
    ld_valid = 1'b0;
    #1 chk("ldr_in_reset", {15'd0, ld_ready}, 16'd0);
    @(posedge Clk1);
    #1;
    chk("rst_data", DataIn, 16'h0000);
    chk("rst_err", {15'd0, err}, 16'd0);
    chk("rst_cnt", wr_count, 16'd0);
    @(negedge Clk1);
    Reset = 1'b0; WR = 1'b0;
    #1 wait_clear("reset");
  endtask

  initial begin
    Reset = 1'b0; RD = 1'b0; WR = 1'b0; Addr = '0; dataOut = '0;
    ld_valid = 1'b0; ld_addr = '0; ld_data = '0;
    do_reset(1'b0);

    //   rd wr addr      dout      ldv lda       ldd       ldr data      err cnt
    vec(0, 0, 16'd0,    16'h0,    1, 16'd5,    16'h4123, 1, 16'h0000, 0, 16'd0);
    vec(0, 0, 16'd0,    16'h0,    1, 16'd9,    16'h1111, 1, 16'h0000, 0, 16'd0);
    vec(1, 0, 16'd5,    16'h0,    0, 16'd0,    16'h0,    0, 16'h4123, 0, 16'd0);
    vec(0, 1, 16'd7,    16'hBEEF, 0, 16'd0,    16'h0,    0, 16'h4123, 0, 16'd1);
    vec(1, 0, 16'd7,    16'h0,    0, 16'd0,    16'h0,    0, 16'hBEEF, 0, 16'd1);
    vec(1, 0, 16'd9,    16'h0,    1, 16'd9,    16'h2222, 0, 16'h1111, 0, 16'd1);
    vec(1, 0, 16'd9,    16'h0,    0, 16'd0,    16'h0,    0, 16'h1111, 0, 16'd1);
    vec(0, 0, 16'd0,    16'h0,    1, 16'd9,    16'h2222, 1, 16'h1111, 0, 16'd1);
    vec(1, 0, 16'd9,    16'h0,    0, 16'd0,    16'h0,    0, 16'h2222, 0, 16'd1);
    vec(1, 0, 16'd5,    16'h0,    0, 16'd0,    16'h0,    0, 16'h4123, 0, 16'd1);
    vec(1, 0, 16'd7,    16'h0,    0, 16'd0,    16'h0,    0, 16'hBEEF, 0, 16'd1);
    vec(1, 0, 16'd9,    16'h0,    0, 16'd0,    16'h0,    0, 16'h2222, 0, 16'd1);
    vec(0, 1, 16'd3,    16'h0033, 0, 16'd0,    16'h0,    0, 16'h2222, 0, 16'd2);
    vec(0, 1, 16'd0,    16'h1234, 0, 16'd0,    16'h0,    0, 16'h2222, 0, 16'd3);
    vec(1, 0, 16'd3,    16'h0,    0, 16'd0,    16'h0,    0, 16'h0033, 0, 16'd3);
    vec(1, 1, 16'd3,    16'hDEAD, 0, 16'd0,    16'h0,    0, 16'h0033, 1, 16'd3);
    vec(1, 0, 16'd3,    16'h0,    0, 16'd0,    16'h0,    0, 16'h0033, 1, 16'd3);
    vec(1, 0, 16'h0400, 16'h0,    0, 16'd0,    16'h0,    0, 16'h0000, 1, 16'd3);
    vec(0, 1, 16'h0400, 16'h5555, 0, 16'd0,    16'h0,    0, 16'h0000, 1, 16'd3);
    vec(1, 0, 16'd0,    16'h0,    0, 16'd0,    16'h0,    0, 16'h1234, 1, 16'd3);
    vec(0, 0, 16'd0,    16'h0,    0, 16'd0,    16'h0,    1, 16'h1234, 1, 16'd3);
    vec(0, 0, 16'd0,    16'h0,    1, 16'h0400, 16'h5555, 1, 16'h1234, 1, 16'd3);
    vec(1, 0, 16'd0,    16'h0,    0, 16'd0,    16'h0,    0, 16'h1234, 1, 16'd3);

    for (int i = 0; i < vq.size(); i++) begin
      cyc(vq[i].rd, vq[i].wr, vq[i].addr, vq[i].dout, vq[i].ldv, vq[i].lda, vq[i].ldd);
      chk($sformatf("v%0d_ldr", i), {15'd0, ldr_s}, {15'd0, vq[i].exp_ldr});
      chk($sformatf("v%0d_data", i), DataIn, vq[i].exp_data);
      chk($sformatf("v%0d_err", i), {15'd0, err}, {15'd0, vq[i].exp_err});
      chk($sformatf("v%0d_cnt", i), wr_count, vq[i].exp_cnt);
    end

    // Reset with a same-cycle write: the write is dropped.
    do_reset(1'b1);
    cyc(1, 0, 16'd7, 16'h0, 0, 16'd0, 16'h0);
`ifdef CVP14_MEM_CLEAR_EN
    chk("post_rst_rd7", DataIn, INIT);
`else
    chk("post_rst_rd7", DataIn, 16'hBEEF);
`endif
    chk("post_rst_cnt", wr_count, 16'd0);

    // Out-of-range loader write alone sets err and does not alias to word 0.
    cyc(0, 0, 16'd0, 16'h0, 1, 16'h8000, 16'h7777);
    chk("ld_oor_ldr", {15'd0, ldr_s}, 16'd1);
    chk("ld_oor_err", {15'd0, err}, 16'd1);
    cyc(1, 0, 16'd0, 16'h0, 0, 16'd0, 16'h0);
`ifdef CVP14_MEM_CLEAR_EN
    chk("ld_oor_rd0", DataIn, INIT);
`else
    chk("ld_oor_rd0", DataIn, 16'h1234);
`endif
    chk("ld_oor_cnt", wr_count, 16'd0);

`ifdef CVP14_MEM_CLEAR_EN
    // Sweep restart: reset at sweep word 9 while core traffic must be ignored.
    @(negedge Clk1);
    Reset = 1'b1; RD = 1'b0; WR = 1'b1; Addr = 16'h0400; dataOut = 16'h0;
    ld_valid = 1'b0;
    @(negedge Clk1);
    Reset = 1'b0;
    repeat (9) @(posedge Clk1);
    #1 chk("sweep9_busy", {15'd0, busy}, 16'd1);
    @(negedge Clk1);
    Reset = 1'b1; Addr = 16'd2; dataOut = 16'h1234;
    @(negedge Clk1);
    Reset = 1'b0;
    #1 wait_clear("restart");
    @(negedge Clk1);
    WR = 1'b0;
    #1;
    chk("restart_err", {15'd0, err}, 16'd0);
    chk("restart_cnt", wr_count, 16'd0);
    for (int a = 0; a < DEPTH; a++) begin
      cyc(1, 0, 16'(a), 16'h0, 0, 16'd0, 16'h0);
      chk($sformatf("clear_rd%0d", a), DataIn, INIT);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
